// File: rtl/lx32_mc_ctrl.sv
// LX32 multi-cycle control sequencer: fetch, decode, exec, mem, writeback, trap and bus watchdog.
// Defining LX32_CTRL_PERF_EN adds the perf_cycles_o/perf_retired_o counters.
module lx32_mc_ctrl #(
   parameter int unsigned BUS_TIMEOUT   = 256,
   parameter bit          RESET_PC_HOLD = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        halt_req_i,
   output logic        imem_req_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic        branch_taken_i,
   output logic [31:0] ir_o,
   output logic        pc_we_o,
   output logic [1:0]  pc_sel_o,
   output logic        rf_we_o,
   output logic [1:0]  wb_sel_o,
   output logic        retire_o,
   output logic        trap_o,
   output logic [1:0]  trap_cause_o,
   output logic [2:0]  state_o
`ifdef LX32_CTRL_PERF_EN
   ,
   output logic [31:0] perf_cycles_o,
   output logic [31:0] perf_retired_o
`endif
);

   localparam logic [2:0] S_FETCH    = 3'd0;
   localparam logic [2:0] S_WAIT_I   = 3'd1;
   localparam logic [2:0] S_DECODE   = 3'd2;
   localparam logic [2:0] S_EXEC     = 3'd3;
   localparam logic [2:0] S_MEM_REQ  = 3'd4;
   localparam logic [2:0] S_MEM_WAIT = 3'd5;
   localparam logic [2:0] S_WB       = 3'd6;
   localparam logic [2:0] S_HALT     = 3'd7;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_MISC   = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam int unsigned     WD_W     = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
   localparam int unsigned     WD_LIM_I = (BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_LIM_I[WD_W-1:0];
   localparam bit              WD_EN    = (BUS_TIMEOUT != 0);

   logic [2:0]      state_q, state_d;
   logic [31:0]     ir_q, ir_d;
   logic            trap_q, trap_d;
   logic [1:0]      cause_q, cause_d;
   logic            taken_q, taken_d;
   logic            req_active_q, req_active_d;
   logic [WD_W-1:0] wd_q, wd_d;

   logic [6:0] opcode;
   logic       is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
   logic       is_imm, is_op, is_misc, is_system, legal, rd_nz;
   logic       wd_wait, wd_expire, wd_dmem;

   assign opcode    = ir_q[6:0];
   assign is_lui    = (opcode == OP_LUI);
   assign is_auipc  = (opcode == OP_AUIPC);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_imm    = (opcode == OP_IMM);
   assign is_op     = (opcode == OP_OP);
   assign is_misc   = (opcode == OP_MISC);
   assign is_system = (opcode == OP_SYSTEM);
   assign legal     = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store
                    | is_imm | is_op | is_misc | is_system;
   assign rd_nz     = |ir_q[11:7];

   assign wd_dmem   = (state_q == S_MEM_REQ) || (state_q == S_MEM_WAIT);
   assign wd_wait   = (state_q == S_FETCH) || (state_q == S_WAIT_I) || wd_dmem;
   assign wd_expire = WD_EN && wd_wait && (wd_q == WD_LIMIT);

   // Outputs are decoded from state; rst_n gating makes requests fall the moment reset asserts.
   always_comb begin
      imem_req_o = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      pc_we_o    = 1'b0;
      pc_sel_o   = 2'b00;
      rf_we_o    = 1'b0;
      wb_sel_o   = 2'b00;
      retire_o   = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_FETCH:   imem_req_o = req_active_q || !halt_req_i;
            S_MEM_REQ: begin
               dmem_req_o = 1'b1;
               dmem_we_o  = is_store;
            end
            S_WB: begin
               pc_we_o  = 1'b1;
               retire_o = 1'b1;
               rf_we_o  = (is_lui | is_auipc | is_jal | is_jalr | is_load | is_imm | is_op) & rd_nz;
               if (is_jal || (is_branch && taken_q)) pc_sel_o = 2'b01;
               else if (is_jalr)                     pc_sel_o = 2'b10;
               if (is_lui)                 wb_sel_o = 2'b11;
               else if (is_jal || is_jalr) wb_sel_o = 2'b10;
               else if (is_load)           wb_sel_o = 2'b01;
            end
            default: ;
         endcase
      end
   end

   // A halt is only honoured before the fetch request goes out; once raised it is held to gnt.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      trap_d  = trap_q;
      cause_d = cause_q;
      taken_d = taken_q;
      case (state_q)
         S_FETCH: begin
            if (!req_active_q && halt_req_i) state_d = S_HALT;
            else if (imem_gnt_i)             state_d = S_WAIT_I;
         end
         S_WAIT_I: begin
            if (imem_rvalid_i) begin
               ir_d    = imem_rdata_i;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (legal) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_HALT;
               trap_d  = 1'b1;
               cause_d = 2'b01;
            end
         end
         S_EXEC: begin
            taken_d = branch_taken_i;
            state_d = (is_load || is_store) ? S_MEM_REQ : S_WB;
         end
         S_MEM_REQ:  if (dmem_gnt_i)    state_d = is_store ? S_WB : S_MEM_WAIT;
         S_MEM_WAIT: if (dmem_rvalid_i) state_d = S_WB;
         S_WB:       state_d = S_FETCH;
         default:    if (!trap_q && !halt_req_i) state_d = S_FETCH;
      endcase
      // A handshake in the final allowed cycle still wins over the watchdog.
      if (wd_expire && (state_d == state_q)) begin
         state_d = S_HALT;
         trap_d  = 1'b1;
         cause_d = wd_dmem ? 2'b11 : 2'b10;
      end
   end

   always_comb begin
      req_active_d = (state_q == S_FETCH) && imem_req_o && (state_d == S_FETCH);
      wd_d         = '0;
      if (WD_EN && wd_wait && (state_d == state_q)) wd_d = wd_q + WD_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RESET_PC_HOLD ? S_HALT : S_FETCH;
         ir_q         <= NOP;
         trap_q       <= 1'b0;
         cause_q      <= 2'b00;
         taken_q      <= 1'b0;
         req_active_q <= 1'b0;
         wd_q         <= '0;
      end else begin
         state_q      <= state_d;
         ir_q         <= ir_d;
         trap_q       <= trap_d;
         cause_q      <= cause_d;
         taken_q      <= taken_d;
         req_active_q <= req_active_d;
         wd_q         <= wd_d;
      end
   end

   assign ir_o         = ir_q;
   assign trap_o       = trap_q;
   assign trap_cause_o = cause_q;
   assign state_o      = state_q;

`ifdef LX32_CTRL_PERF_EN
   logic [31:0] perf_cycles_q, perf_retired_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles_q  <= '0;
         perf_retired_q <= '0;
      end else begin
         perf_cycles_q <= perf_cycles_q + 32'd1;
         if (retire_o) perf_retired_q <= perf_retired_q + 32'd1;
      end
   end

   assign perf_cycles_o  = perf_cycles_q;
   assign perf_retired_o = perf_retired_q;
`endif

endmodule

// File: tb/tb_lx32_mc_ctrl.sv
// Self-checking bench for lx32_mc_ctrl: per-instruction expected output timelines built from the
// instruction class and handshake delays, compared every cycle, plus literal latency/select checks.
module tb_lx32_mc_ctrl;

   localparam int BT = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        halt_req_i, imem_gnt_i, imem_rvalid_i, dmem_gnt_i, dmem_rvalid_i, branch_taken_i;
   logic [31:0] imem_rdata_i;
   logic        imem_req_o, dmem_req_o, dmem_we_o, pc_we_o, rf_we_o, retire_o, trap_o;
   logic [1:0]  pc_sel_o, wb_sel_o, trap_cause_o;
   logic [31:0] ir_o;
   logic [2:0]  state_o;
`ifdef LX32_CTRL_PERF_EN
   logic [31:0] perf_cycles_o, perf_retired_o;
`endif

   always #5 clk = ~clk;

   lx32_mc_ctrl #(.BUS_TIMEOUT(BT), .RESET_PC_HOLD(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .halt_req_i(halt_req_i),
      .imem_req_o(imem_req_o), .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i(imem_rdata_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
      .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .branch_taken_i(branch_taken_i),
      .ir_o(ir_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .rf_we_o(rf_we_o),
      .wb_sel_o(wb_sel_o), .retire_o(retire_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o),
      .state_o(state_o)
`ifdef LX32_CTRL_PERF_EN
      , .perf_cycles_o(perf_cycles_o), .perf_retired_o(perf_retired_o)
`endif
   );

   typedef struct packed {
      logic       imemReq;
      logic       dmemReq;
      logic       dmemWe;
      logic       pcWe;
      logic       rfWe;
      logic [1:0] pcSel;
      logic [1:0] wbSel;
      logic       retire;
      logic       trap;
      logic [1:0] cause;
      logic [2:0] state;
   } outs_t;

   outs_t       expO;
   logic [31:0] expIr;
   logic [31:0] irModel = 32'h13;
   logic        expValid = 1'b0;
   logic        haltMid = 1'b0;
   logic        abortMemWait = 1'b0;
   logic        tracking = 1'b0;
   int          relCyc, retireAt, dreqCnt, ireqCnt;
   logic        rfWeR;
   logic [1:0]  pcSelR, wbSelR;
   int          checks = 0;
   int          errors = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the expected timeline.
   always @(negedge clk) begin
      if (expValid && rst_n) begin
         checkOutput("imem_req_o", 32'(imem_req_o), 32'(expO.imemReq));
         checkOutput("dmem_req_o", 32'(dmem_req_o), 32'(expO.dmemReq));
         checkOutput("dmem_we_o", 32'(dmem_we_o), 32'(expO.dmemWe));
         checkOutput("pc_we_o", 32'(pc_we_o), 32'(expO.pcWe));
         checkOutput("rf_we_o", 32'(rf_we_o), 32'(expO.rfWe));
         checkOutput("pc_sel_o", 32'(pc_sel_o), 32'(expO.pcSel));
         checkOutput("wb_sel_o", 32'(wb_sel_o), 32'(expO.wbSel));
         checkOutput("retire_o", 32'(retire_o), 32'(expO.retire));
         checkOutput("trap_o", 32'(trap_o), 32'(expO.trap));
         checkOutput("trap_cause_o", 32'(trap_cause_o), 32'(expO.cause));
         checkOutput("state_o", 32'(state_o), 32'(expO.state));
         checkOutput("ir_o", ir_o, expIr);
      end
   end

   always @(negedge clk) begin
      if (tracking) begin
         relCyc++;
         if (retire_o) begin
            retireAt = relCyc;
            rfWeR    = rf_we_o;
            pcSelR   = pc_sel_o;
            wbSelR   = wb_sel_o;
         end
         if (dmem_req_o) dreqCnt++;
         if (imem_req_o) ireqCnt++;
      end
   end

   task automatic clearInputs();
      halt_req_i     = 1'b0;
      imem_gnt_i     = 1'b0;
      imem_rvalid_i  = 1'b0;
      imem_rdata_i   = 32'h0;
      dmem_gnt_i     = 1'b0;
      dmem_rvalid_i  = 1'b0;
      branch_taken_i = 1'b0;
   endtask

   function automatic outs_t idle(input logic [2:0] st);
      outs_t o;
      o       = '0;
      o.state = st;
      return o;
   endfunction

   task automatic step(input outs_t e);
      expO     = e;
      expIr    = irModel;
      expValid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic trapHold(input logic [1:0] cause, input int n);
      outs_t e;
      e       = idle(3'd7);
      e.trap  = 1'b1;
      e.cause = cause;
      for (int i = 0; i < n; i++) begin
         clearInputs();
         imem_gnt_i    = 1'b1;
         imem_rvalid_i = 1'b1;
         dmem_gnt_i    = 1'b1;
         step(e);
      end
   endtask

   // Instruction-class rules: what WB must show and whether a data phase happens.
   task automatic classify(input logic [31:0] ins, input logic tk, output logic legal,
                           output logic isMem, output logic isStore, output logic rfWe,
                           output logic [1:0] pcSel, output logic [1:0] wbSel);
      legal = 1'b1; isMem = 1'b0; isStore = 1'b0; rfWe = 1'b0; pcSel = 2'b00; wbSel = 2'b00;
      case (ins[6:0])
         7'h37:        begin rfWe = 1'b1; wbSel = 2'b11; end
         7'h17:        rfWe = 1'b1;
         7'h6f:        begin rfWe = 1'b1; wbSel = 2'b10; pcSel = 2'b01; end
         7'h67:        begin rfWe = 1'b1; wbSel = 2'b10; pcSel = 2'b10; end
         7'h63:        pcSel = tk ? 2'b01 : 2'b00;
         7'h03:        begin isMem = 1'b1; rfWe = 1'b1; wbSel = 2'b01; end
         7'h23:        begin isMem = 1'b1; isStore = 1'b1; end
         7'h13, 7'h33: rfWe = 1'b1;
         7'h0f, 7'h73: ;
         default:      legal = 1'b0;
      endcase
      if (ins[11:7] == 5'd0) rfWe = 1'b0;
   endtask

   // One instruction: fg/rv = fetch gnt/rvalid wait cycles, mg/mr = data gnt/rvalid wait cycles.
   task automatic applyStimulus(input logic [31:0] ins, input int fg, input int rv,
                                input int mg, input int mr, input logic tk);
      logic legal, isMem, isStore, rfWe;
      logic [1:0] pcSel, wbSel;
      outs_t e;
      classify(ins, tk, legal, isMem, isStore, rfWe, pcSel, wbSel);
      tracking = 1'b1; relCyc = 0; retireAt = 0; dreqCnt = 0; ireqCnt = 0;
      rfWeR = 1'b0; pcSelR = 2'b00; wbSelR = 2'b00;
      for (int i = 0; i <= fg; i++) begin
         if (i == BT) begin trapHold(2'b10, 4); tracking = 1'b0; return; end
         clearInputs();
         if (i > 0) halt_req_i = haltMid;
         if (i == fg) begin
            imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hdeadbeef;
         end
         e = idle(3'd0); e.imemReq = 1'b1; step(e);
      end
      for (int i = 0; i <= rv; i++) begin
         if (i == BT) begin trapHold(2'b10, 4); tracking = 1'b0; return; end
         clearInputs();
         halt_req_i = haltMid;
         if (i == rv) begin imem_rvalid_i = 1'b1; imem_rdata_i = ins; end
         step(idle(3'd1));
      end
      irModel = ins;
      clearInputs(); halt_req_i = haltMid; branch_taken_i = !tk;
      step(idle(3'd2));
      if (!legal) begin trapHold(2'b01, 20); tracking = 1'b0; return; end
      clearInputs(); halt_req_i = haltMid; branch_taken_i = tk;
      step(idle(3'd3));
      if (isMem) begin
         for (int i = 0; i <= mg; i++) begin
            if (i == BT) begin trapHold(2'b11, 4); tracking = 1'b0; return; end
            clearInputs(); halt_req_i = haltMid; branch_taken_i = !tk;
            dmem_gnt_i = (i == mg);
            e = idle(3'd4); e.dmemReq = 1'b1; e.dmemWe = isStore; step(e);
         end
         if (!isStore) begin
            for (int i = 0; i <= mr; i++) begin
               if (abortMemWait && i == 1) begin tracking = 1'b0; return; end
               if (i == BT) begin trapHold(2'b11, 4); tracking = 1'b0; return; end
               clearInputs(); halt_req_i = haltMid; branch_taken_i = !tk;
               dmem_rvalid_i = (i == mr);
               step(idle(3'd5));
            end
         end
      end
      clearInputs(); halt_req_i = haltMid; branch_taken_i = !tk;
      e = idle(3'd6); e.pcWe = 1'b1; e.retire = 1'b1; e.rfWe = rfWe; e.pcSel = pcSel; e.wbSel = wbSel;
      step(e);
      tracking = 1'b0;
   endtask

   // Called at a FETCH entry with halt high; HALT is left the cycle after halt drops.
   task automatic doHalt(input int n);
      clearInputs(); halt_req_i = 1'b1; imem_gnt_i = 1'b1;
      step(idle(3'd0));
      for (int i = 0; i < n; i++) begin
         clearInputs(); halt_req_i = 1'b1;
         step(idle(3'd7));
      end
      clearInputs();
      step(idle(3'd7));
   endtask

   task automatic checkResetVals(input string tag);
      checkOutput({tag, " ir_o"}, ir_o, 32'h0000_0013);
      checkOutput({tag, " state_o"}, 32'(state_o), 32'd0);
      checkOutput({tag, " trap_o"}, 32'(trap_o), 32'd0);
      checkOutput({tag, " trap_cause_o"}, 32'(trap_cause_o), 32'd0);
      checkOutput({tag, " imem_req_o"}, 32'(imem_req_o), 32'd0);
      checkOutput({tag, " dmem_req_o"}, 32'(dmem_req_o), 32'd0);
      checkOutput({tag, " strobes"}, 32'({pc_we_o, rf_we_o, retire_o, dmem_we_o}), 32'd0);
      checkOutput({tag, " sels"}, 32'({pc_sel_o, wb_sel_o}), 32'd0);
   endtask

   task automatic doReset();
      expValid = 1'b0;
      clearInputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      irModel = 32'h13;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL global time limit reached");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      clearInputs();
      #12;
      checkResetVals("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      applyStimulus(32'h00410093, 0, 0, 0, 0, 1'b0);
      checkOutput("addi retire cycle", retireAt, 5);
      checkOutput("addi rf_we", 32'(rfWeR), 32'd1);
      checkOutput("addi wb_sel", 32'(wbSelR), 32'd0);
      checkOutput("addi pc_sel", 32'(pcSelR), 32'd0);

      applyStimulus(32'h00012083, 0, 0, 2, 0, 1'b0);
      checkOutput("lw retire cycle", retireAt, 9);
      checkOutput("lw dmem_req cycles", dreqCnt, 3);
      checkOutput("lw wb_sel", 32'(wbSelR), 32'd1);
      checkOutput("lw rf_we", 32'(rfWeR), 32'd1);

      applyStimulus(32'h00112223, 0, 0, 0, 0, 1'b0);
      checkOutput("sw retire cycle", retireAt, 6);
      checkOutput("sw rf_we", 32'(rfWeR), 32'd0);
      checkOutput("sw pc_sel", 32'(pcSelR), 32'd0);

      applyStimulus(32'hfe000ce3, 0, 0, 0, 0, 1'b1);
      checkOutput("beq taken pc_sel", 32'(pcSelR), 32'd1);
      checkOutput("beq taken rf_we", 32'(rfWeR), 32'd0);
      applyStimulus(32'hfe000ce3, 0, 0, 0, 0, 1'b0);
      checkOutput("beq not-taken pc_sel", 32'(pcSelR), 32'd0);

      applyStimulus(32'h008000ef, 1, 2, 0, 0, 1'b0);
      checkOutput("jal wb_sel", 32'(wbSelR), 32'd2);
      checkOutput("jal pc_sel", 32'(pcSelR), 32'd1);
      applyStimulus(32'h000080e7, 0, 0, 0, 0, 1'b1);
      checkOutput("jalr pc_sel", 32'(pcSelR), 32'd2);
      applyStimulus(32'h123452b7, 0, 0, 0, 0, 1'b0);
      checkOutput("lui wb_sel", 32'(wbSelR), 32'd3);
      applyStimulus(32'h00000013, 0, 0, 0, 0, 1'b0);
      checkOutput("nop rd0 rf_we", 32'(rfWeR), 32'd0);
      applyStimulus(32'h0000000f, 0, 0, 0, 0, 1'b0);
      applyStimulus(32'h00000073, 0, 1, 0, 0, 1'b0);
      applyStimulus(32'h00012083, 0, 0, 0, 2, 1'b0);
      checkOutput("lw slow rvalid retire", retireAt, 9);
      applyStimulus(32'h002081b3, 0, 0, 0, 0, 1'b0);
      applyStimulus(32'h00410093, BT - 1, 0, 0, 0, 1'b0);
      checkOutput("fetch gnt at last cycle retire", retireAt, 12);

      haltMid = 1'b1;
      applyStimulus(32'h00012083, 2, 0, 1, 0, 1'b0);
      doHalt(3);
      haltMid = 1'b0;
      applyStimulus(32'h00410093, 0, 0, 0, 0, 1'b0);
      checkOutput("after halt retire", retireAt, 5);

      applyStimulus(32'hffffffff, 0, 0, 0, 0, 1'b0);
      checkOutput("illegal trap_o", 32'(trap_o), 32'd1);
      checkOutput("illegal cause", 32'(trap_cause_o), 32'd1);
      checkOutput("illegal imem_req count", ireqCnt, 1);

      doReset();
      applyStimulus(32'h00410093, 20, 0, 0, 0, 1'b0);
      checkOutput("imem timeout cause", 32'(trap_cause_o), 32'd2);
      checkOutput("imem timeout req cycles", ireqCnt, BT);

      doReset();
      applyStimulus(32'h00112223, 0, 0, 20, 0, 1'b0);
      checkOutput("dmem timeout cause", 32'(trap_cause_o), 32'd3);
      checkOutput("dmem timeout req cycles", dreqCnt, BT);

      doReset();
      abortMemWait = 1'b1;
      applyStimulus(32'h00012083, 0, 0, 0, 5, 1'b0);
      abortMemWait = 1'b0;
      checkOutput("pre-abort state", 32'(state_o), 32'd5);
      expValid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checkResetVals("abort");
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      irModel = 32'h13;
      applyStimulus(32'h00410093, 0, 0, 0, 0, 1'b0);
      checkOutput("restart retire cycle", retireAt, 5);

      expValid = 1'b0;
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lx32_mc_ctrl.md
Name: lx32_mc_ctrl

Overview:
Multi-cycle control sequencer for the LX32 core. Fetches an instruction over a req/gnt/rvalid bus and latches it into the instruction register, which feeds imm_gen and the decoder. It then steps the shared datapath (regfile, ALU, imm_gen, data port) through decode, execute, memory and writeback. It also owns PC update, writeback select, trap entry and bus-timeout supervision.

Parameters:
BUS_TIMEOUT, 256, cycles waited for gnt/rvalid before trapping; 0 disables the watchdog.
RESET_PC_HOLD, 0, 1 = stay in HALT after reset until halt_req_i drops; 0 = go directly to FETCH.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
halt_req_i  in  1  debug halt request, honoured only at an instruction boundary
imem_req_o  out  1  instruction fetch request
imem_gnt_i  in  1  fetch request accepted
imem_rvalid_i  in  1  fetch data valid
imem_rdata_i  in  32  fetched instruction
dmem_req_o  out  1  data request
dmem_we_o  out  1  1 = store
dmem_gnt_i  in  1  data request accepted
dmem_rvalid_i  in  1  load data valid
branch_taken_i  in  1  ALU compare result, sampled in EXEC
ir_o  out  32  instruction register, drives imm_gen.instr
pc_we_o  out  1  PC write strobe
pc_sel_o  out  2  00 pc+4, 01 pc+imm (branch/JAL), 10 rs1+imm (JALR)
rf_we_o  out  1  regfile write strobe
wb_sel_o  out  2  00 ALU, 01 load data, 10 pc+4, 11 imm (LUI)
retire_o  out  1  one-cycle pulse per completed instruction
trap_o  out  1  sticky trap flag
trap_cause_o  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
state_o  out  3  current FSM state, for debug

Behaviour:
- Reset (async assert, sync release): state FETCH (or HALT if RESET_PC_HOLD=1); ir_o=0x00000013 (NOP); trap_o=0; trap_cause_o=00; all strobes and requests 0; sel outputs 00; watchdog counter 0.
- States: FETCH=0, WAIT_I=1, DECODE=2, EXEC=3, MEM_REQ=4, MEM_WAIT=5, WB=6, HALT/TRAP=7.
- FETCH: imem_req_o=1 held until imem_gnt_i; on gnt go to WAIT_I. If halt_req_i is high on entry to FETCH, go to HALT instead and raise no request.
- WAIT_I: on imem_rvalid_i, ir_o<=imem_rdata_i, go to DECODE. rvalid in the same cycle as gnt is not accepted; it must arrive in WAIT_I.
- DECODE: 1 cycle; imm_gen and regfile settle. Opcode ir_o[6:0] is checked against LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM. Any other opcode goes to TRAP with cause 01.
- EXEC: 1 cycle; latches branch_taken_i. LOAD and STORE go to MEM_REQ; everything else goes to WB.
- MEM_REQ: dmem_req_o=1, dmem_we_o=(STORE), held stable until dmem_gnt_i. On gnt, a store goes to WB and a load goes to MEM_WAIT.
- MEM_WAIT: on dmem_rvalid_i go to WB.
- WB: 1 cycle, then FETCH.
  - pc_we_o=1 and retire_o=1.
  - rf_we_o=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP; forced to 0 when ir_o[11:7]==0.
  - pc_sel_o: 01 for JAL, or BRANCH with the latched taken=1; 10 for JALR; else 00.
  - wb_sel_o: 11 for LUI, 10 for JAL/JALR, 01 for LOAD, else 00.
  - MISC-MEM and SYSTEM are retired as NOPs.
- Minimum latency: ALU/branch/jump 5 cycles; store 6; load 7 (gnt in the first cycle, rvalid in the next cycle).
- Watchdog:
  - Counts cycles spent in FETCH, WAIT_I, MEM_REQ and MEM_WAIT; clears on every state change.
  - Reaching BUS_TIMEOUT traps with cause 10 (imem states) or 11 (dmem states).
  - Requests drop in the trap cycle.
- HALT/TRAP:
  - No requests and no strobes are issued.
  - A trap holds until reset.
  - A halt (trap_o=0) returns to FETCH the cycle after halt_req_i deasserts.
- halt_req_i asserted mid-instruction has no effect until the next FETCH entry.
- Reset mid-transaction aborts immediately: requests drop asynchronously and no retire occurs.

Optional Feature:
LX32_CTRL_PERF_EN: adds outputs perf_cycles_o[31:0] (increments every cycle outside reset) and perf_retired_o[31:0] (increments on retire_o). Both wrap modulo 2^32 and reset to 0. When the macro is undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- ADDI x1,x2,4 (0x00410093), gnt immediate, rvalid next cycle -> retire_o at cycle 5; rf_we_o=1, wb_sel_o=00, pc_sel_o=00; ir_o=0x00410093 from DECODE onward.
- LW x1,0(x2) (0x00012083), dmem_gnt delayed 2 cycles -> dmem_req_o high 3 cycles with dmem_we_o=0; WB with wb_sel_o=01, rf_we_o=1; retire at cycle 9.
- SW x1,4(x2) (0x00112223) -> dmem_we_o=1; WB has rf_we_o=0, pc_sel_o=00; retire at cycle 6.
- BEQ x0,x0,-8 (0xfe000ce3): with branch_taken_i=1 -> pc_sel_o=01; with branch_taken_i=0 -> pc_sel_o=00. rf_we_o=0 in both cases.
- Illegal 0xffffffff -> trap_o=1, trap_cause_o=01 one cycle after DECODE; no further imem_req_o for 20 cycles.
- BUS_TIMEOUT=8 with imem_gnt_i held 0 -> trap_cause_o=10 after 8 FETCH cycles. rst_n pulse during MEM_WAIT -> all outputs at reset values immediately, restart at FETCH.
